// File: rtl/unary_gen_9.sv
// rtl/unary_gen_9.sv - binary-to-unary pulse stream generator
//
// Converts a 9-bit binary value into a unary pulse train on a single
// registered output bit, for use as one operand of a downstream 9-bit
// unary adder.
//
// Build option:
//   UNARY_GEN_GAP_EN  defined   : every pulse is followed by one forced-low
//                                 cycle (1,0,1,0...), two cycles per unit.
//   UNARY_GEN_GAP_EN  undefined : pulses are back-to-back, one unit per cycle.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset
//   en         in   run enable; 0 pauses an active stream
//   load       in   start request; only sampled while ready=1
//   din[8:0]   in   value to emit as a unary pulse count (0..511)
//   ready      out  high in IDLE; load is accepted
//   busy       out  high in RUN
//   pulse      out  registered unary stream bit
//   done       out  one-cycle registered strobe at end of stream
//   remaining  out  pulses still to emit

module unary_gen_9 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [8:0] din,
    output logic       ready,
    output logic       busy,
    output logic       pulse,
    output logic       done,
    output logic [8:0] remaining
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    logic [8:0] r_remaining;
    logic       r_pulse;
    logic       r_done;
    logic       w_phase;
    logic       w_last;

    // Nothing left to emit: the next active phase-0 cycle ends the stream.
    assign w_last = (r_remaining == 9'd0);

`ifdef UNARY_GEN_GAP_EN
    // phase=1 marks the forced-low cycle that follows each emitted pulse.
    logic r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (load) begin
                r_phase <= 1'b0;
            end
        end else if (en) begin
            // Enter the gap only after a real pulse; leave it unconditionally.
            r_phase <= !r_phase && !w_last;
        end
    end

    assign w_phase = r_phase;
`else
    assign w_phase = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= 9'd0;
            r_pulse     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // pulse and done are strobes; they only rise in the branches below.
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_remaining <= din;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // load is ignored here, din is not re-sampled.
                    if (en) begin
                        if (w_phase) begin
                            r_pulse <= 1'b0;
                        end else if (!w_last) begin
                            r_pulse     <= 1'b1;
                            r_remaining <= r_remaining - 9'd1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign pulse     = r_pulse;
    assign done      = r_done;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_unary_gen_9.sv
// tb/tb_unary_gen_9.sv - directed self-checking bench for unary_gen_9
`timescale 1ns/1ps

module tb_unary_gen_9;

`ifdef UNARY_GEN_GAP_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif
    localparam int BOUND = 2000;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [8:0] din;
    logic       ready;
    logic       busy;
    logic       pulse;
    logic       done;
    logic [8:0] remaining;

    int n_checks = 0;
    int n_errors = 0;

    unary_gen_9 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .din       (din),
        .ready     (ready),
        .busy      (busy),
        .pulse     (pulse),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d);
        din  = d[8:0];
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Run until done; returns pulses seen and edges taken.
    task automatic wait_done(output int pulses, output int cycles, output bit ok);
        pulses = 0;
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < BOUND) begin
            step();
            cycles++;
            if (pulse === 1'b1) pulses++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    // Called right after the load edge; checks the whole stream cycle by cycle.
    task automatic run_check(input int d, input string tag);
        int  c, bad, pulses, exp_r;
        bit  exp_p, got_done, rdy_at_done;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_rem_init"}, {23'd0, remaining}, d);
        c = 0; bad = 0; pulses = 0; got_done = 0; rdy_at_done = 0;
        while (!got_done && c < BOUND) begin
            step();
            c++;
            if (K == 2) begin
                exp_p = (c % 2 == 1) && (c <= 2 * d - 1);
                exp_r = d - (c + 1) / 2;
            end else begin
                exp_p = (c <= d);
                exp_r = d - c;
            end
            if (exp_r < 0) exp_r = 0;
            if (pulse !== exp_p || remaining !== exp_r[8:0]) bad++;
            if (pulse === 1'b1) pulses++;
            if (done === 1'b1) begin
                got_done    = 1'b1;
                rdy_at_done = ready;
            end
        end
        chk({tag, "_pattern_bad"}, bad, 0);
        chk({tag, "_pulses"}, pulses, d);
        chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
        chk({tag, "_done_cycle"}, c, 1 + d * K);
        chk({tag, "_ready_at_done"}, {31'd0, rdy_at_done}, 32'd1);
    endtask

    initial begin
        int  p, cyc, bad, c2;
        bit  ok;

        rst = 1'b1; en = 1'b1; load = 1'b0; din = 9'd0;
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulse", {31'd0, pulse}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rem", {23'd0, remaining}, 32'd0);
        rst = 1'b0;
        step();

        // load ignored while en=0? No: acceptance ignores en.
        en = 1'b0;
        do_load(1);
        chk("load_en0_busy", {31'd0, busy}, 32'd1);
        en = 1'b1;
        wait_done(p, cyc, ok);
        chk("load_en0_pulses", p, 32'd1);

        do_load(5);
        run_check(5, "d5");
        step();
        chk("d5_done_drop", {31'd0, done}, 32'd0);

        do_load(0);
        run_check(0, "d0");
        chk("d0_busy_after", {31'd0, busy}, 32'd0);

        do_load(511);
        run_check(511, "d511");

        do_load(9);
        run_check(9, "d9");

        // Pause after the second pulse.
        c2 = (K == 2) ? 3 : 2;
        do_load(4);
        p = 0;
        for (int i = 0; i < c2; i++) begin
            step();
            if (pulse === 1'b1) p++;
        end
        chk("pause_pre_pulses", p, 32'd2);
        chk("pause_pre_rem", {23'd0, remaining}, 32'd2);
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (pulse !== 1'b0 || remaining !== 9'd2 || busy !== 1'b1) bad++;
        end
        chk("pause_hold_bad", bad, 32'd0);
        en = 1'b1;
        wait_done(p, cyc, ok);
        chk("pause_done_seen", {31'd0, ok}, 32'd1);
        chk("pause_post_pulses", p, 32'd2);

        // Mid-stream load ignored, load on the done cycle accepted.
        din  = 9'd3;
        load = 1'b1;
        step();
        din = 9'd7;
        wait_done(p, cyc, ok);
        chk("b2b_first_done", {31'd0, ok}, 32'd1);
        chk("b2b_first_pulses", p, 32'd3);
        chk("b2b_first_cycles", cyc, 1 + 3 * K);
        step();
        load = 1'b0;
        chk("b2b_second_busy", {31'd0, busy}, 32'd1);
        chk("b2b_second_rem", {23'd0, remaining}, 32'd7);
        wait_done(p, cyc, ok);
        chk("b2b_second_done", {31'd0, ok}, 32'd1);
        chk("b2b_second_pulses", p, 32'd7);
        chk("b2b_second_cycles", cyc, 1 + 7 * K);

        // Reset mid-stream.
        do_load(6);
        for (int i = 0; i < c2; i++) step();
        chk("abort_rem_pre", {23'd0, remaining}, 32'd4);
        rst = 1'b1;
        step();
        chk("abort_pulse", {31'd0, pulse}, 32'd0);
        chk("abort_rem", {23'd0, remaining}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        do_load(2);
        chk("reload_busy", {31'd0, busy}, 32'd1);
        wait_done(p, cyc, ok);
        chk("reload_done", {31'd0, ok}, 32'd1);
        chk("reload_pulses", p, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
